// File: rtl/mux_select_arbiter_if.sv
// Request/grant bundle between eight requesters and the mux select arbiter.
//   req       : level request per requester (bit i = requester i)
//   grant     : one-hot grant, all zeros when no owner
//   select    : binary index of the current owner, drives the mux select
//   valid     : high while a grant is active
//   preempted : one-cycle pulse when a grant changed hands on hold-limit expiry
// master = requester side, slave = arbiter side.
interface mux_select_arbiter_if;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] select;
    logic       valid;
    logic       preempted;

    modport master (
        output req,
        input  grant,
        input  select,
        input  valid,
        input  preempted
    );

    modport slave (
        input  req,
        output grant,
        output select,
        output valid,
        output preempted
    );
endinterface

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter sharing one 8-way, 32-bit select mux among eight requesters.
// The owner keeps the grant while it requests; it is pre-empted after MAX_HOLD
// consecutive cycles when another requester is waiting (MAX_HOLD = 0: never).
// Ports:
//   clock : system clock, all state changes on the rising edge
//   reset : synchronous, active-high reset
//   bus   : slave side of mux_select_arbiter_if (req in; grant, select, valid,
//           preempted out, all registered)
module mux_select_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input logic                  clock,
    input logic                  reset,
    mux_select_arbiter_if.slave  bus
);

    if (MAX_HOLD < 0 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux_select_arbiter: MAX_HOLD=%0d outside legal range 0..255", MAX_HOLD);
    end

    localparam logic [7:0] HoldLim   = 8'(MAX_HOLD);
    // Counter ceiling: the hold limit, or free-running saturation when unlimited.
    localparam logic [7:0] SatLim    = (MAX_HOLD == 0) ? 8'hFF : HoldLim;
    localparam bit         PreemptEn = (MAX_HOLD != 0);

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    state_e     state;
    logic [2:0] last;
    logic [7:0] hold_cnt;
    logic [7:0] grant_q;
    logic [2:0] select_q;
    logic       valid_q;
    logic       preempted_q;

    logic       owner_req;
    logic [7:0] others;
    logic [7:0] cand;
    logic [2:0] winner;

    // First set bit of cand searching circularly upward from after+1.
    // Scanning offsets high-to-low lets the nearest hit overwrite farther ones.
    function automatic logic [2:0] rr_pick(input logic [7:0] c, input logic [2:0] after);
        logic [2:0] idx;
        logic [2:0] pick;
        pick = after;
        for (int i = 8; i >= 1; i--) begin
            idx = after + 3'(i);
            if (c[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    always_comb begin
        owner_req = bus.req[select_q];
        others    = bus.req & ~(8'b1 << select_q);
        // In GRANT the owner is always excluded; on a release its bit is already low.
        cand      = (state == StIdle) ? bus.req : others;
        winner    = rr_pick(cand, last);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= StIdle;
            grant_q     <= 8'h00;
            select_q    <= 3'd0;
            valid_q     <= 1'b0;
            preempted_q <= 1'b0;
            last        <= 3'd7;
            hold_cnt    <= 8'd0;
        end else begin
            preempted_q <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (|bus.req) begin
                        state    <= StGrant;
                        grant_q  <= 8'b1 << winner;
                        select_q <= winner;
                        valid_q  <= 1'b1;
                        last     <= winner;
                        hold_cnt <= 8'd1;
                    end
                end
                StGrant: begin
                    if (!owner_req) begin
                        // Release wins over a simultaneous expiry: no pulse.
                        if (|others) begin
                            grant_q  <= 8'b1 << winner;
                            select_q <= winner;
                            last     <= winner;
                            hold_cnt <= 8'd1;
                        end else begin
                            state    <= StIdle;
                            grant_q  <= 8'h00;
                            valid_q  <= 1'b0;
                        end
                    end else if (PreemptEn && hold_cnt == HoldLim && |others) begin
                        grant_q     <= 8'b1 << winner;
                        select_q    <= winner;
                        last        <= winner;
                        hold_cnt    <= 8'd1;
                        preempted_q <= 1'b1;
                    end else if (hold_cnt != SatLim) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.select    = select_q;
    assign bus.valid     = valid_q;
    assign bus.preempted = preempted_q;

endmodule

// File: tb/tb_mux_select_arbiter.sv
module tb_mux_select_arbiter;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] grant;
        logic [2:0] sel;
        logic       valid;
        logic       pre;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    mux_select_arbiter_if bus();

    mux_select_arbiter #(.MAX_HOLD(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    vec_t sb[$];
    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Drive one cycle of stimulus, queue its expected outputs, compare after the edge.
    task automatic apply(input logic rst, input logic [7:0] req, input logic [7:0] eg,
                         input logic [2:0] es, input logic ev, input logic ep,
                         input string name);
        vec_t e;
        @(negedge clock);
        reset   = rst;
        bus.req = req;
        e = '{rst: rst, req: req, grant: eg, sel: es, valid: ev, pre: ep};
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        n_vec++;
        if (bus.grant !== e.grant) begin
            $display("FAIL %s grant: got %h want %h", name, bus.grant, e.grant);
            n_miss++;
        end
        if (bus.select !== e.sel) begin
            $display("FAIL %s select: got %0d want %0d", name, bus.select, e.sel);
            n_miss++;
        end
        if (bus.valid !== e.valid) begin
            $display("FAIL %s valid: got %b want %b", name, bus.valid, e.valid);
            n_miss++;
        end
        if (bus.preempted !== e.pre) begin
            $display("FAIL %s preempted: got %b want %b", name, bus.preempted, e.pre);
            n_miss++;
        end
    endtask

    initial begin
        bus.req = 8'hFF;

        // {rst, req, grant, select, valid, preempted}
        tbl.push_back('{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0}); // in reset
        tbl.push_back('{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0}); // first pick = 0
        tbl.push_back('{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0}); // release to idle
        tbl.push_back('{1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0}); // select held
        tbl.push_back('{1'b0, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0}); // idle stays
        tbl.push_back('{1'b0, 8'h80, 8'h80, 3'd7, 1'b1, 1'b0}); // pointer to 7
        tbl.push_back('{1'b0, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h81, 8'h01, 3'd0, 1'b1, 1'b0}); // wrap to 0
        tbl.push_back('{1'b0, 8'h81, 8'h01, 3'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 8'h80, 8'h80, 3'd7, 1'b1, 1'b0}); // no bubble
        tbl.push_back('{1'b0, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0}); // wrap search from 0
        tbl.push_back('{1'b0, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'h80, 8'h80, 3'd7, 1'b1, 1'b0}); // pointer back to 7
        tbl.push_back('{1'b0, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0});

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].req, tbl[i].grant, tbl[i].sel, tbl[i].valid,
                  tbl[i].pre, $sformatf("table[%0d]", i));
        end

        // Pre-emption ping-pong with req = 0x03: 4 cycles each, one-cycle pulse.
        for (int r = 0; r < 3; r++) begin
            logic [7:0] g;
            logic [2:0] s;
            g = (r % 2 == 0) ? 8'h01 : 8'h02;
            s = (r % 2 == 0) ? 3'd0 : 3'd1;
            for (int c = 0; c < 4; c++) begin
                apply(1'b0, 8'h03, g, s, 1'b1, (r != 0 && c == 0),
                      $sformatf("preempt r%0d c%0d", r, c));
            end
        end
        apply(1'b0, 8'h03, 8'h02, 3'd1, 1'b1, 1'b1, "preempt back to 1");
        apply(1'b0, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0, "preempt release");

        // Lone requester past the limit: kept, no pulse.
        for (int c = 0; c < 20; c++) begin
            apply(1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0, $sformatf("lone c%0d", c));
        end

        // Owner 3 then reset mid-grant with all requesting.
        apply(1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0, "owner3");
        apply(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, "mid reset");
        apply(1'b0, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0, "after reset");
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0, $sformatf("all req hold c%0d", c));
        end
        apply(1'b0, 8'hFF, 8'h02, 3'd1, 1'b1, 1'b1, "all req preempt");
        for (int c = 0; c < 3; c++) begin
            apply(1'b0, 8'hFF, 8'h02, 3'd1, 1'b1, 1'b0, $sformatf("owner1 hold c%0d", c));
        end
        // Release coinciding with expiry counts as a release.
        apply(1'b0, 8'hFD, 8'h04, 3'd2, 1'b1, 1'b0, "release at expiry");
        apply(1'b0, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0, "final idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
